// File: rtl/oam_dma_pkg.sv
// Shared PPU/APU definitions: DMA state encoding and the two bus addresses
// the sprite DMA cares about.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: copies page {P,00..FF} into OAMDATA as 256 read/write pairs,
// halting the CPU through o_rdy. All bus outputs are registered.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic        i_reg_wr,
    input  logic [7:0]  i_reg_data,
    input  logic [7:0]  i_data,
    output logic        o_rdy,
    output logic        o_active,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data
);

    dma_state_t r_state;
    logic       r_put;
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic [7:0] r_buf;

    logic [7:0] w_next_idx;
    logic       w_last;

    assign w_next_idx = r_index + 8'd1;
    assign w_last     = (r_index == 8'hFF);
    // The byte buffer doubles as the write-data output; it is zero outside a transfer.
    assign o_data     = r_buf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_put     <= 1'b0;
            r_page    <= 8'h00;
            r_index   <= 8'h00;
            r_buf     <= 8'h00;
            o_rdy     <= 1'b1;
            o_active  <= 1'b0;
            o_address <= 16'h0000;
            o_rw      <= 1'b1;
        end else if (i_ce) begin
            r_put <= ~r_put;
            case (r_state)
                ST_IDLE: begin
                    if (i_reg_wr) begin
                        r_page  <= i_reg_data;
                        r_index <= 8'h00;
                        r_state <= ST_HALT;
                        o_rdy   <= 1'b0;
                    end
                end
                ST_HALT: begin
                    o_active <= 1'b1;
                    o_rw     <= 1'b1;
                    // r_put low now means the following cycle is a put; READ must be a get.
                    if (!r_put) begin
                        r_state   <= ST_ALIGN;
                        o_address <= {r_page, 8'h00};
                    end else begin
                        r_state   <= ST_READ;
                        o_address <= {r_page, r_index};
                    end
                end
                ST_ALIGN: begin
                    r_state   <= ST_READ;
                    o_address <= {r_page, r_index};
                end
                ST_READ: begin
                    r_buf     <= i_data;
                    r_state   <= ST_WRITE;
                    o_address <= OAMDATA_ADDR;
                    o_rw      <= 1'b0;
                end
                ST_WRITE: begin
                    r_index <= w_next_idx;
                    if (!w_last) begin
                        r_state   <= ST_READ;
                        o_address <= {r_page, w_next_idx};
                        o_rw      <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_buf     <= 8'h00;
                        o_rdy     <= 1'b1;
                        o_active  <= 1'b0;
                        o_address <= 16'h0000;
                        o_rw      <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    o_rdy     <= 1'b1;
                    o_active  <= 1'b0;
                    o_address <= 16'h0000;
                    o_rw      <= 1'b1;
                end
            endcase
        end
    end

endmodule
